blink_meter: RTL and testbench

//  Receive-side counterpart of the LED blink generator: samples an asynchronous square

---
 rtl/blink_pkg.sv | 17 +
 rtl/blink_meter_if.sv | 28 ++
 rtl/sync_edge_det.sv | 29 ++
 rtl/blink_meter.sv | 162 ++++++++++++++++
 tb/tb_blink_meter.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/blink_pkg.sv
// Shared constants for the blink generator / blink meter pair.
package blink_pkg;

  // Measurement FSM encodings, kept as plain constants for legacy tools.
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  // Blinker toggles every BLINK_HALF_PERIOD clocks; the meter expects the same.
  localparam int unsigned BLINK_HALF_PERIOD = 5001;

  // Lower edge of the match window, clamped at zero when TOL exceeds EXPECTED.
  function automatic int unsigned lower_bound(input int unsigned expected,
                                              input int unsigned tol);
    return (expected > tol) ? (expected - tol) : 0;
  endfunction

endpackage

// File: rtl/blink_meter_if.sv
// Result channel of the blink meter: valid/ready handshake plus payload.
interface blink_meter_if #(
  parameter int unsigned CNT_W = 26
);
  logic             meas_valid;
  logic             meas_ready;
  logic [CNT_W-1:0] meas_count;
  logic             meas_level;
  logic             match;

  // Producer side (the meter).
  modport master (
    output meas_valid,
    output meas_count,
    output meas_level,
    output match,
    input  meas_ready
  );

  // Consumer side.
  modport slave (
    input  meas_valid,
    input  meas_count,
    input  meas_level,
    input  match,
    output meas_ready
  );
endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser plus history flop; flags either-polarity edges.
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o,
  output logic edge_o
);
  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Synchronise the asynchronous input and keep one cycle of history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s3_q;
  assign edge_o  = s2_q ^ s3_q;

endmodule

// File: rtl/blink_meter.sv
// Half-period meter for an asynchronous square wave with tolerance check,
// lock tracking, no-activity timeout and a valid/ready result channel.
module blink_meter
  import blink_pkg::*;
#(
  parameter int unsigned CNT_W    = 26,
  parameter int unsigned EXPECTED = BLINK_HALF_PERIOD,
  parameter int unsigned TOL      = 16,
  parameter int unsigned TIMEOUT  = 50000,
  parameter int unsigned LOCK_N   = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 sig_in,
  blink_meter_if.master        meas,
  output logic                 overrun,
  output logic                 timeout,
  output logic                 locked
);

  localparam int unsigned CW1  = CNT_W + 1;
  localparam int unsigned LK_W = $clog2(LOCK_N + 1);

  localparam logic [CNT_W:0]   WIN_LO   = CW1'(lower_bound(EXPECTED, TOL));
  localparam logic [CNT_W:0]   WIN_HI   = CW1'(EXPECTED + TOL);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [LK_W-1:0]  LOCK_MAX = LK_W'(LOCK_N);

  logic             level_s;
  logic             edge_s;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic             locked_q, locked_d;
  logic             timeout_q;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             level_q, level_d;
  logic             match_q, match_d;
  logic             overrun_q, overrun_d;

  logic             cnt_sat;
  logic             produce;
  logic             tmo_hit;
  logic [CNT_W:0]   interval_w;
  logic [CNT_W-1:0] new_count;
  logic             new_match;
  logic [LK_W-1:0]  lock_inc;

  sync_edge_det u_sync (
    .clk_i   (CLOCK_50),
    .rst_i   (reset),
    .async_i (sig_in),
    .level_o (level_s),
    .edge_o  (edge_s)
  );

  // Interval is cnt+1 in one extra bit so the window compare cannot wrap;
  // a saturated counter reports all-ones and never matches.
  always_comb begin
    cnt_sat    = &cnt_q;
    interval_w = {1'b0, cnt_q} + CW1'(1);
    new_count  = cnt_sat ? '1 : interval_w[CNT_W-1:0];
    new_match  = !cnt_sat && (interval_w >= WIN_LO) && (interval_w <= WIN_HI);
    produce    = (state_q == ST_MEASURE) && edge_s;
    tmo_hit    = (state_q == ST_MEASURE) && !edge_s && (cnt_q == TMO_LAST);
  end

  // Interval counter: restart on every edge, otherwise count up and saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (edge_s)        cnt_d = '0;
    else if (!cnt_sat) cnt_d = cnt_q + CNT_W'(1);
  end

  // FSM: the first edge only arms measurement; a silent TIMEOUT disarms it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (edge_s)  state_d = ST_MEASURE;
      ST_MEASURE: if (tmo_hit) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Lock tracking sees every produced interval, whether or not it is delivered.
  always_comb begin
    lock_inc   = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + LK_W'(1);
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (tmo_hit) begin
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else if (produce) begin
      if (new_match) begin
        lock_cnt_d = lock_inc;
        if (lock_inc == LOCK_MAX) locked_d = 1'b1;
      end else begin
        lock_cnt_d = '0;
        locked_d   = 1'b0;
      end
    end
  end

  // Result register: load when empty or being accepted, else drop and flag overrun.
  always_comb begin
    valid_d   = valid_q;
    count_d   = count_q;
    level_d   = level_q;
    match_d   = match_q;
    overrun_d = overrun_q;
    if (produce) begin
      if (!valid_q || meas.meas_ready) begin
        valid_d = 1'b1;
        count_d = new_count;
        level_d = level_s;
        match_d = new_match;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && meas.meas_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      timeout_q  <= 1'b0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      level_q    <= 1'b0;
      match_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      timeout_q  <= tmo_hit;
      valid_q    <= valid_d;
      count_q    <= count_d;
      level_q    <= level_d;
      match_q    <= match_d;
      overrun_q  <= overrun_d;
    end
  end

  assign meas.meas_valid = valid_q;
  assign meas.meas_count = count_q;
  assign meas.meas_level = level_q;
  assign meas.match      = match_q;
  assign overrun         = overrun_q;
  assign timeout         = timeout_q;
  assign locked          = locked_q;

endmodule

// File: tb/tb_blink_meter.sv
// Directed bench for blink_meter: nominal lock, mismatch, timeout,
// back-pressure/overrun, async reset and window boundaries.
module tb_blink_meter;
  import blink_pkg::*;

  localparam int unsigned CNT_W = 26;
  localparam int unsigned TMO   = 8000;

  logic clk = 1'b0;
  logic rst;
  logic sig;
  logic overrun, timeout, locked;

  int vecs = 0;
  int errs = 0;

  blink_meter_if #(.CNT_W(CNT_W)) bus ();

  blink_meter #(
    .CNT_W    (CNT_W),
    .EXPECTED (5001),
    .TOL      (16),
    .TIMEOUT  (TMO),
    .LOCK_N   (4)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .sig_in   (sig),
    .meas     (bus),
    .overrun  (overrun),
    .timeout  (timeout),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             lvl;
    logic             m;
  } res_t;

  res_t q[$];
  bit   mon_en = 1'b0;

  // Record every accepted result.
  always @(negedge clk) begin
    if (mon_en && !rst && bus.meas_valid && bus.meas_ready)
      q.push_back({bus.meas_count, bus.meas_level, bus.match});
  end

  function automatic res_t take();
    if (q.size() == 0) return '0;
    return q.pop_front();
  endfunction

  function automatic logic [CNT_W+5:0] outs();
    return {bus.meas_valid, bus.meas_count, bus.meas_level, bus.match,
            overrun, timeout, locked};
  endfunction

  // Single toggle, then let it propagate through sync and result register.
  task automatic first_edge();
    @(negedge clk);
    sig = ~sig;
    repeat (4) @(negedge clk);
    #1;
  endtask

  // Toggle n clocks after the previous toggle, then settle.
  task automatic interval(input int n);
    repeat (n - 4) @(negedge clk);
    sig = ~sig;
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    sig = 1'b0;
    bus.meas_ready = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    vecs++;
    if (outs() !== '0) begin
      errs++; $display("FAIL reset_outs: got %h want 0", outs());
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vecs++;
    if (outs() !== '0) begin
      errs++; $display("FAIL post_reset_outs: got %h want 0", outs());
    end
  endtask

  task automatic test_nominal();
    res_t r;
    q.delete();
    bus.meas_ready = 1'b1;
    mon_en = 1'b1;
    first_edge();
    vecs++;
    if (q.size() !== 0) begin
      errs++; $display("FAIL t1_first_edge_nres: got %0d want 0", q.size());
    end
    for (int i = 0; i < 4; i++) begin
      interval(5001);
      vecs++;
      if (q.size() !== 1) begin
        errs++; $display("FAIL t1_nres[%0d]: got %0d want 1", i, q.size());
      end
      r = take();
      vecs++;
      if (r.cnt !== 26'd5001) begin
        errs++; $display("FAIL t1_count[%0d]: got %0d want 5001", i, r.cnt);
      end
      vecs++;
      if (r.m !== 1'b1) begin
        errs++; $display("FAIL t1_match[%0d]: got %0d want 1", i, r.m);
      end
      vecs++;
      if (r.lvl !== ~sig) begin
        errs++; $display("FAIL t1_level[%0d]: got %0d want %0d", i, r.lvl, ~sig);
      end
      vecs++;
      if (locked !== (i == 3)) begin
        errs++; $display("FAIL t1_locked[%0d]: got %0d want %0d", i, locked, (i == 3));
      end
    end
  endtask

  task automatic test_mismatch();
    res_t r;
    q.delete();
    interval(4000);
    r = take();
    vecs++;
    if (r.cnt !== 26'd4000) begin
      errs++; $display("FAIL t2_count: got %0d want 4000", r.cnt);
    end
    vecs++;
    if (r.m !== 1'b0) begin
      errs++; $display("FAIL t2_match: got %0d want 0", r.m);
    end
    vecs++;
    if (locked !== 1'b0) begin
      errs++; $display("FAIL t2_locked: got %0d want 0", locked);
    end
  endtask

  task automatic test_timeout();
    int   lens [4] = '{5017, 4985, 5011, 4991};
    int   seen = 0;
    logic lock_before = 1'b0;
    res_t r;
    q.delete();
    // Relock using intervals on and near the window edges.
    for (int i = 0; i < 4; i++) begin
      interval(lens[i]);
      r = take();
      vecs++;
      if (r.cnt !== CNT_W'(lens[i]) || r.m !== 1'b1) begin
        errs++; $display("FAIL t3_relock_res[%0d]: got %0d/%0d want %0d/1",
                         i, r.cnt, r.m, lens[i]);
      end
      vecs++;
      if (locked !== (i == 3)) begin
        errs++; $display("FAIL t3_relock_locked[%0d]: got %0d want %0d", i, locked, (i == 3));
      end
    end
    // Freeze sig_in; the result register updated 3 negedges after the toggle,
    // so the timeout pulse is due TMO negedges after that.
    for (int k = 5; k <= int'(TMO) + 10; k++) begin
      @(negedge clk);
      if (timeout) begin seen = k; break; end
      if (k == int'(TMO) + 2) lock_before = locked;
    end
    vecs++;
    if (seen !== int'(TMO) + 3) begin
      errs++; $display("FAIL t3_timeout_time: got %0d want %0d", seen, TMO + 3);
    end
    vecs++;
    if (lock_before !== 1'b1) begin
      errs++; $display("FAIL t3_locked_before: got %0d want 1", lock_before);
    end
    vecs++;
    if (locked !== 1'b0) begin
      errs++; $display("FAIL t3_locked_after: got %0d want 0", locked);
    end
    @(negedge clk);
    vecs++;
    if (timeout !== 1'b0) begin
      errs++; $display("FAIL t3_timeout_pulse_width: got %0d want 0", timeout);
    end
    first_edge();
    vecs++;
    if (q.size() !== 0) begin
      errs++; $display("FAIL t3_rearm_nres: got %0d want 0", q.size());
    end
    interval(300);
    r = take();
    vecs++;
    if (r.cnt !== 26'd300) begin
      errs++; $display("FAIL t3_after_rearm_count: got %0d want 300", r.cnt);
    end
  endtask

  task automatic test_back_to_back();
    mon_en = 1'b0;
    bus.meas_ready = 1'b0;
    interval(100);
    vecs++;
    if (bus.meas_valid !== 1'b1 || bus.meas_count !== 26'd100 || overrun !== 1'b0) begin
      errs++; $display("FAIL t4_first_held: got v%0d c%0d o%0d want v1 c100 o0",
                       bus.meas_valid, bus.meas_count, overrun);
    end
    interval(100);
    vecs++;
    if (bus.meas_valid !== 1'b1 || bus.meas_count !== 26'd100) begin
      errs++; $display("FAIL t4_old_kept: got v%0d c%0d want v1 c100",
                       bus.meas_valid, bus.meas_count);
    end
    vecs++;
    if (overrun !== 1'b1) begin
      errs++; $display("FAIL t4_overrun: got %0d want 1", overrun);
    end
    @(negedge clk);
    bus.meas_ready = 1'b1;
    @(negedge clk);
    #1;
    vecs++;
    if (bus.meas_valid !== 1'b0) begin
      errs++; $display("FAIL t4_accept: got %0d want 0", bus.meas_valid);
    end
    repeat (20) @(negedge clk);
    vecs++;
    if (bus.meas_valid !== 1'b0 || overrun !== 1'b1) begin
      errs++; $display("FAIL t4_idle_after_accept: got v%0d o%0d want v0 o1",
                       bus.meas_valid, overrun);
    end
  endtask

  task automatic test_async_reset();
    res_t r;
    bus.meas_ready = 1'b0;
    first_edge();
    vecs++;
    if (bus.meas_valid !== 1'b1) begin
      errs++; $display("FAIL t5_valid_before_reset: got %0d want 1", bus.meas_valid);
    end
    repeat (20) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    vecs++;
    if (outs() !== '0) begin
      errs++; $display("FAIL t5_async_outs: got %h want 0", outs());
    end
    sig = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    q.delete();
    bus.meas_ready = 1'b1;
    mon_en = 1'b1;
    first_edge();
    vecs++;
    if (q.size() !== 0 || bus.meas_valid !== 1'b0) begin
      errs++; $display("FAIL t5_first_discarded: got n%0d v%0d want n0 v0",
                       q.size(), bus.meas_valid);
    end
    interval(200);
    r = take();
    vecs++;
    if (r.cnt !== 26'd200 || r.m !== 1'b0) begin
      errs++; $display("FAIL t5_second_result: got %0d/%0d want 200/0", r.cnt, r.m);
    end
  endtask

  task automatic test_window_edges();
    res_t r;
    q.delete();
    interval(5018);
    r = take();
    vecs++;
    if (r.cnt !== 26'd5018 || r.m !== 1'b0) begin
      errs++; $display("FAIL t6_above_hi: got %0d/%0d want 5018/0", r.cnt, r.m);
    end
    interval(4984);
    r = take();
    vecs++;
    if (r.cnt !== 26'd4984 || r.m !== 1'b0) begin
      errs++; $display("FAIL t6_below_lo: got %0d/%0d want 4984/0", r.cnt, r.m);
    end
    vecs++;
    if (locked !== 1'b0 || overrun !== 1'b0) begin
      errs++; $display("FAIL t6_flags: got l%0d o%0d want l0 o0", locked, overrun);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_mismatch();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    test_window_edges();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
